io_handshake_unit: RTL and testbench
====================================

Name: io_handshake_unit

Overview:
- Responder for the processor's IN/OUT instructions.
- Control asserts I or O together with Halt, which freezes the PC; this block services the request and then pulses `release` so the PC advances.
- IN: captures the board switches on a debounced confirm-button press and presents them on `in_data`, which feeds write-back source 2'b10.
- OUT: latches the register value for the display, then waits for a confirm press.

Parameters:
- SWITCH_W, 16, switch bus width; must be 1..32.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- I, input, 1, IN request from Control.
- O, input, 1, OUT request from Control.
- out_data, input, 32, register value to display for OUT.
- switches, input, SWITCH_W, raw switch levels.
- confirm_btn, input, 1, raw asynchronous push button, active-high.
- in_data, output, 32, captured switches, zero-extended, to the write-back mux.
- display_value, output, 32, last OUT value.
- display_valid, output, 1, high once any OUT has completed its latch.
- release, output, 1, one-cycle pulse that lets the PC advance past IN/OUT.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - Returns the FSM to IDLE.
  - Clears all outputs, the synchronizer, the debounce counter, the debounced level and the edge register to 0.
  - Applies mid-operation too: a pending IN/OUT is abandoned, no release is produced, and the display is cleared.
- Button path:
  - Two-flop synchronizer, then debounce.
  - Debounce: while synchronized level differs from the debounced level, the counter increments; on any match it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level toggles and the counter clears.
  - press_event is a registered one-cycle pulse on a debounced 0→1 transition.
  - Latency: with raw held high, press_event is high in the cycle after edge DEBOUNCE_CYCLES+2, counting the first edge that samples raw high as edge 1.
  - Glitches shorter than DEBOUNCE_CYCLES never produce an event.
- FSM states: IDLE, IN_WAIT, OUT_WAIT, DONE.
- IDLE:
  - I=1 → IN_WAIT. I takes priority if I and O are both 1.
  - else O=1 → OUT_WAIT. On the same edge, display_value <= out_data and display_valid <= 1.
  - press_event in IDLE is discarded, not queued.
- IN_WAIT:
  - press_event=1 → DONE. On the same edge, in_data <= {zero pad, switches}, with switches sampled at that edge.
  - I=0 (request withdrawn) → IDLE, no release, in_data unchanged.
- OUT_WAIT:
  - press_event=1 → DONE.
  - O=0 → IDLE, no release; display keeps its value.
- DONE:
  - release=1 for exactly this one cycle. The PC advances and the register file writes in_data at the end of this cycle.
  - Next state is always IDLE.
- busy = (state != IDLE). release is 0 in every state except DONE.
- Held button: holding the button across back-to-back IN instructions does not complete the second IN. A release then a new press is required, because the debounced level must return to 0 first.
- Register hold: in_data and display_value hold until overwritten or reset.
- Width: SWITCH_W < 32 zero-fills in_data[31:SWITCH_W]; SWITCH_W = 32 copies switches directly.
- Counter wrap: the counter never wraps, since it clears at DEBOUNCE_CYCLES-1.

Test Plan:
- IN, DEBOUNCE_CYCLES=4, SWITCH_W=16:
  - Stimulus: reset; I=1; switches=16'hA5C3; confirm_btn held high from edge 1.
  - Required: busy=1; press_event after edge 6; in_data=32'h0000A5C3 and release=1 for exactly one cycle after edge 7; then IDLE with busy=0.
- OUT:
  - Stimulus: O=1, out_data=32'hDEADBEEF.
  - Required: display_value=32'hDEADBEEF and display_valid=1 on the first edge; no release until a debounced press; single release pulse; display holds after O drops.
- Glitch rejection:
  - Stimulus: IN pending; confirm_btn high for 2 cycles three times, separated by low gaps.
  - Required: no press_event, no release, in_data unchanged.
- Back-to-back IN, button held:
  - Stimulus: first IN completes; button stays high; I stays high for the next IN.
  - Required: no second release until the button goes low ≥4 stable cycles and is pressed again.
- Async reset:
  - Stimulus: reset asserted mid-clock while in IN_WAIT with the debounce counter at 2.
  - Required: all outputs 0 immediately, without waiting for an edge; after reset the old press does not complete an IN.
- Simultaneous requests and idle press:
  - Stimulus: I=1 and O=1 together.
  - Required: IN_WAIT entered; display unchanged.
  - Stimulus: press while IDLE, then assert I.
  - Required: the press is ignored and the IN still waits for a fresh press.

Source files
------------

// File: rtl/io_handshake_if.sv
// Handshake bundle between Control/board and the IN/OUT responder.
// slave = the responder, master = the Control/board side driving requests.
interface io_handshake_if #(
    parameter int SWITCH_W = 16
);
    logic                I;
    logic                O;
    logic [31:0]         out_data;
    logic [SWITCH_W-1:0] switches;
    logic                confirm_btn;
    logic [31:0]         in_data;
    logic [31:0]         display_value;
    logic                display_valid;
    logic                pc_release;
    logic                busy;
    logic [1:0]          state_dbg;
    logic                press_dbg;

    // Request/release handshake: Control raises I or O and holds it (PC frozen)
    // until pc_release pulses for one cycle; dropping the request early abandons
    // it without any pc_release.
    modport slave (
        input  I, O, out_data, switches, confirm_btn,
        output in_data, display_value, display_valid, pc_release, busy,
               state_dbg, press_dbg
    );

    modport master (
        output I, O, out_data, switches, confirm_btn,
        input  in_data, display_value, display_valid, pc_release, busy,
               state_dbg, press_dbg
    );
endinterface

// File: rtl/io_handshake_unit.sv
// IN/OUT responder: debounced confirm button, switch capture for IN,
// display latch for OUT, and a one-cycle pc_release to let the PC advance.
module io_handshake_unit #(
    parameter int SWITCH_W        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic          clock,
    input  logic          reset,
    io_handshake_if.slave bus
);
    if (SWITCH_W < 1 || SWITCH_W > 32) begin : g_bad_switch_w
        $error("SWITCH_W must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_WAIT  = 2'd1,
        OUT_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic               sync1;
    logic               sync2;
    logic               deb_level;
    logic               press_event;
    logic               mismatch;
    logic [CNT_W-1:0]   deb_cnt;
    logic [31:0]        switches_ext;
    logic [31:0]        in_data_q;
    logic [31:0]        display_value_q;
    logic               display_valid_q;

    assign mismatch     = (sync2 != deb_level);
    assign switches_ext = 32'(bus.switches);

    // Button path; press_event fires on the same edge the debounced level rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            deb_level   <= 1'b0;
            deb_cnt     <= '0;
            press_event <= 1'b0;
        end else begin
            sync1       <= bus.confirm_btn;
            sync2       <= sync1;
            press_event <= 1'b0;
            if (!mismatch) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                deb_level   <= ~deb_level;
                deb_cnt     <= '0;
                press_event <= ~deb_level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.I)      state_next = IN_WAIT;
                else if (bus.O) state_next = OUT_WAIT;
            end
            IN_WAIT: begin
                if (press_event) state_next = DONE;
                else if (!bus.I) state_next = IDLE;
            end
            OUT_WAIT: begin
                if (press_event) state_next = DONE;
                else if (!bus.O) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Data registers load on the same edges that leave IDLE for OUT_WAIT
    // and IN_WAIT for DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_data_q       <= '0;
            display_value_q <= '0;
            display_valid_q <= 1'b0;
        end else begin
            if (state == IDLE && !bus.I && bus.O) begin
                display_value_q <= bus.out_data;
                display_valid_q <= 1'b1;
            end
            if (state == IN_WAIT && press_event) begin
                in_data_q <= switches_ext;
            end
        end
    end

    always_comb begin
        bus.busy          = (state != IDLE);
        bus.pc_release    = (state == DONE);
        bus.state_dbg     = state;
        bus.press_dbg     = press_event;
        bus.in_data       = in_data_q;
        bus.display_value = display_value_q;
        bus.display_valid = display_valid_q;
    end
endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for io_handshake_unit: directed scenarios with literal expectations
// plus a long randomized run against a behavioural model.
module tb_io_handshake_unit;
    localparam int D  = 4;
    localparam int SW = 16;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    io_handshake_if #(.SWITCH_W(SW)) bus ();

    io_handshake_unit #(
        .SWITCH_W(SW),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int          m_state;   // 0 idle, 1 waiting IN, 2 waiting OUT, 3 releasing
    bit          m_s1, m_s2, m_deb, m_press, m_valid;
    bit          win[$];
    logic [31:0] m_in, m_disp;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_state = 0;
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0; m_valid = 0;
        m_in = '0; m_disp = '0;
        win.delete();
        exp_q.delete();
    endtask

    task automatic model_step();
        bit seen;
        bit all_diff;
        int nxt;
        nxt = m_state;
        case (m_state)
            0: if (bus.I) nxt = 1;
               else if (bus.O) begin nxt = 2; m_disp = bus.out_data; m_valid = 1; end
            1: if (m_press) begin nxt = 3; m_in = 32'(bus.switches); end
               else if (!bus.I) nxt = 0;
            2: if (m_press) nxt = 3;
               else if (!bus.O) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 3) exp_q.push_back(m_in);
        m_state = nxt;
        // Level changes once D consecutive synchronized samples disagree with it.
        seen = m_s2; m_s2 = m_s1; m_s1 = bus.confirm_btn;
        win.push_back(seen);
        if (win.size() > D) void'(win.pop_front());
        m_press = 0;
        if (win.size() == D) begin
            all_diff = 1;
            foreach (win[k]) if (win[k] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = !m_deb;
                m_press = m_deb;
                win.delete();
            end
        end
    endtask

    always @(posedge reset) model_reset();
    always @(posedge clock) if (!reset) model_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("busy", 32'(bus.busy), 32'(m_state != 0));
            check("release", 32'(bus.pc_release), 32'(m_state == 3));
            check("press_event", 32'(bus.press_dbg), 32'(m_press));
            check("in_data", bus.in_data, m_in);
            check("display_value", bus.display_value, m_disp);
            check("display_valid", 32'(bus.display_valid), 32'(m_valid));
            if (bus.pc_release) begin
                if (exp_q.size() == 0) check("release_unexpected", 32'(bus.pc_release), 32'd0);
                else check("in_data_at_release", bus.in_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic count_releases(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (bus.pc_release) n++;
        end
    endtask

    task automatic idle_inputs();
        bus.I = 0; bus.O = 0; bus.out_data = '0; bus.switches = '0; bus.confirm_btn = 0;
    endtask

    int n_rel;
    int hold;

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_data", bus.in_data, 32'd0);
        check("rst_display_valid", 32'(bus.display_valid), 32'd0);

        // IN with button held from edge 1
        reset = 1'b0;
        bus.I = 1; bus.switches = 16'hA5C3; bus.confirm_btn = 1;
        @(negedge clock);
        check("in_busy_edge1", 32'(bus.busy), 32'd1);
        repeat (5) @(negedge clock);
        check("in_press_edge6", 32'(bus.press_dbg), 32'd1);
        @(negedge clock);
        check("in_release_edge7", 32'(bus.pc_release), 32'd1);
        check("in_data_edge7", bus.in_data, 32'h0000A5C3);
        @(negedge clock);
        check("in_idle_busy_edge8", 32'(bus.busy), 32'd0);
        check("in_idle_release_edge8", 32'(bus.pc_release), 32'd0);

        // Back-to-back IN with the button still held
        count_releases(12, n_rel);
        check("held_no_second_release", n_rel, 0);
        bus.confirm_btn = 0; bus.switches = 16'h0F0F;
        count_releases(8, n_rel);
        check("held_released_no_release", n_rel, 0);
        bus.confirm_btn = 1;
        count_releases(12, n_rel);
        check("held_repress_one_release", n_rel, 1);
        check("held_in_data", bus.in_data, 32'h00000F0F);
        bus.I = 0; bus.confirm_btn = 0;
        repeat (10) @(negedge clock);

        // Glitch rejection
        bus.switches = 16'hFFFF; bus.I = 1;
        n_rel = 0;
        for (int g = 0; g < 3; g++) begin
            int r;
            bus.confirm_btn = 1;
            count_releases(2, r); n_rel += r;
            bus.confirm_btn = 0;
            count_releases(3, r); n_rel += r;
        end
        check("glitch_no_release", n_rel, 0);
        check("glitch_in_data", bus.in_data, 32'h00000F0F);
        bus.I = 0;
        repeat (2) @(negedge clock);

        // OUT
        bus.O = 1; bus.out_data = 32'hDEADBEEF;
        @(negedge clock);
        check("out_display_value", bus.display_value, 32'hDEADBEEF);
        check("out_display_valid", 32'(bus.display_valid), 32'd1);
        count_releases(6, n_rel);
        check("out_no_release_without_press", n_rel, 0);
        bus.confirm_btn = 1;
        count_releases(10, n_rel);
        check("out_one_release", n_rel, 1);
        bus.O = 0; bus.confirm_btn = 0;
        repeat (8) @(negedge clock);
        check("out_display_holds", bus.display_value, 32'hDEADBEEF);
        check("out_busy_after", 32'(bus.busy), 32'd0);

        // Simultaneous requests: IN wins, display untouched
        bus.I = 1; bus.O = 1; bus.out_data = 32'h11111111;
        @(negedge clock);
        check("both_state_in_wait", 32'(bus.state_dbg), 32'd1);
        check("both_display_unchanged", bus.display_value, 32'hDEADBEEF);
        bus.I = 0; bus.O = 0;
        repeat (2) @(negedge clock);

        // Press while idle is discarded
        bus.confirm_btn = 1;
        repeat (10) @(negedge clock);
        bus.I = 1;
        count_releases(12, n_rel);
        check("idle_press_ignored", n_rel, 0);
        check("idle_press_still_busy", 32'(bus.busy), 32'd1);
        bus.confirm_btn = 0;
        repeat (8) @(negedge clock);
        bus.confirm_btn = 1;
        count_releases(10, n_rel);
        check("idle_then_fresh_press", n_rel, 1);
        bus.I = 0; bus.confirm_btn = 0;
        repeat (8) @(negedge clock);

        // Asynchronous reset mid-cycle with the debounce counter at 2
        bus.I = 1; bus.confirm_btn = 1;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        bus.confirm_btn = 0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_release", 32'(bus.pc_release), 32'd0);
        check("arst_in_data", bus.in_data, 32'd0);
        check("arst_display_value", bus.display_value, 32'd0);
        check("arst_display_valid", 32'(bus.display_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        count_releases(12, n_rel);
        check("arst_old_press_gone", n_rel, 0);
        check("arst_in_wait_busy", 32'(bus.busy), 32'd1);
        bus.I = 0;
        repeat (2) @(negedge clock);

        // Randomized run against the model
        hold = 1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clock);
            if (reset) begin
                #2 reset = 1'b0;
            end
            hold--;
            if (hold <= 0) begin
                bus.confirm_btn = ~bus.confirm_btn;
                hold = $urandom_range(1, 9);
            end
            if ($urandom_range(0, 15) == 0) bus.I = ~bus.I;
            if ($urandom_range(0, 15) == 0) bus.O = ~bus.O;
            bus.switches = SW'($urandom);
            bus.out_data = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
            end
        end
        @(negedge clock);
        #2 reset = 1'b0;
        idle_inputs();
        repeat (4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
